// File: rtl/word_match_counter.sv
// Streaming word splitter: unpacks beats to bytes, extracts alphabetic words and
// counts matches against NUM_KEYS programmable keys plus a total word count.
module word_match_counter #(
   parameter int DATA_WIDTH     = 64,
   parameter int MAX_WORD_BYTES = 16,
   parameter int NUM_KEYS       = 4,
   localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
   localparam int LW  = $clog2(MAX_WORD_BYTES + 1),
   localparam int KW  = 8 * MAX_WORD_BYTES
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_data_valid,
   output logic                     o_data_rdy,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic                     i_flush,
   input  logic                     i_clr_counts,
   input  logic                     i_case_fold,
   input  logic                     i_key_wr,
   input  logic [KIW-1:0]           i_key_idx,
   input  logic [KW-1:0]            i_key_data,
   input  logic [LW-1:0]            i_key_len,
   output logic [32*NUM_KEYS-1:0]   o_count,
   output logic [31:0]              o_words_total,
   output logic                     o_busy
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_WORD_BYTES);

   logic [DATA_WIDTH-1:0]           buf_q, buf_d;
   logic                            full_q, full_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [KW-1:0]                   word_q, word_d;
   logic [LW-1:0]                   len_q, len_d;
   logic                            ovf_q, ovf_d;
   logic [NUM_KEYS-1:0][KW-1:0]     key_data_q, key_data_d;
   logic [NUM_KEYS-1:0][LW-1:0]     key_len_q, key_len_d;
   logic [NUM_KEYS-1:0][31:0]       count_q, count_d;
   logic [31:0]                     total_q, total_d;

   logic [7:0]                      cur_byte_s, letter_s;
   logic                            is_upper_s, is_lower_s, is_letter_s;
   logic                            accept_s, complete_s;
   logic [LW-1:0]                   base_len_s;
   logic [NUM_KEYS-1:0]             match_s;

   assign o_data_rdy    = !full_q || (idx_q == LAST_IDX);
   assign accept_s      = i_data_valid && o_data_rdy;
   assign o_busy        = full_q || (len_q != {LW{1'b0}});
   assign o_count       = count_q;
   assign o_words_total = total_q;

   assign cur_byte_s  = buf_q[{idx_q, 3'b000} +: 8];
   assign is_lower_s  = (cur_byte_s >= 8'h61) && (cur_byte_s <= 8'h7A);
   assign is_upper_s  = (cur_byte_s >= 8'h41) && (cur_byte_s <= 8'h5A);
   assign is_letter_s = is_lower_s || (i_case_fold && is_upper_s);
   assign letter_s    = is_upper_s ? (cur_byte_s + 8'd32) : cur_byte_s;

   // A flush and a byte-stage delimiter both finish the word currently held;
   // after a flush the held word is gone, so at most one completion per cycle.
   assign complete_s = (len_q != {LW{1'b0}}) && (i_flush || (full_q && !is_letter_s));
   assign base_len_s = complete_s ? {LW{1'b0}} : len_q;

   // Per-key comparison against the held word (old key contents on a write edge)
   always_comb begin
      match_s = {NUM_KEYS{1'b0}};
      for (int n = 0; n < NUM_KEYS; n++) begin
         match_s[n] = (key_len_q[n] != {LW{1'b0}}) && (key_len_q[n] == len_q) &&
                      !ovf_q && (key_data_q[n] == word_q);
      end
   end

   // Beat buffer and byte index
   always_comb begin
      buf_d  = buf_q;
      full_d = full_q;
      idx_d  = idx_q;
      if (accept_s) begin
         buf_d  = i_data;
         full_d = 1'b1;
         idx_d  = {IW{1'b0}};
      end else if (full_q) begin
         if (idx_q == LAST_IDX) begin
            full_d = 1'b0;
            idx_d  = {IW{1'b0}};
         end else begin
            idx_d  = idx_q + {{(IW-1){1'b0}}, 1'b1};
         end
      end else begin
         full_d = 1'b0;
      end
   end

   // Word assembly
   always_comb begin
      word_d = complete_s ? {KW{1'b0}} : word_q;
      len_d  = base_len_s;
      ovf_d  = complete_s ? 1'b0 : ovf_q;
      if (full_q && is_letter_s) begin
         if (base_len_s < MAX_LEN) begin
            word_d[{base_len_s, 3'b000} +: 8] = letter_s;
            len_d = base_len_s + {{(LW-1){1'b0}}, 1'b1};
         end else begin
            ovf_d = 1'b1;
         end
      end else begin
         len_d = base_len_s;
      end
   end

   // Saturating counters; clear has priority over a completing word
   always_comb begin
      count_d = count_q;
      total_d = total_q;
      for (int n = 0; n < NUM_KEYS; n++) begin
         if (i_clr_counts) begin
            count_d[n] = 32'd0;
         end else if (complete_s && match_s[n] && (count_q[n] != 32'hFFFF_FFFF)) begin
            count_d[n] = count_q[n] + 32'd1;
         end else begin
            count_d[n] = count_q[n];
         end
      end
      if (i_clr_counts) begin
         total_d = 32'd0;
      end else if (complete_s && (total_q != 32'hFFFF_FFFF)) begin
         total_d = total_q + 32'd1;
      end else begin
         total_d = total_q;
      end
   end

   // Key programming
   always_comb begin
      key_data_d = key_data_q;
      key_len_d  = key_len_q;
      if (i_key_wr && ({{(32-KIW){1'b0}}, i_key_idx} < 32'(NUM_KEYS))) begin
         key_data_d[i_key_idx] = i_key_data;
         key_len_d[i_key_idx]  = i_key_len;
      end else begin
         key_len_d = key_len_q;
      end
   end

   // State registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_q      <= {DATA_WIDTH{1'b0}};
         full_q     <= 1'b0;
         idx_q      <= {IW{1'b0}};
         word_q     <= {KW{1'b0}};
         len_q      <= {LW{1'b0}};
         ovf_q      <= 1'b0;
         key_data_q <= {(NUM_KEYS*KW){1'b0}};
         key_len_q  <= {(NUM_KEYS*LW){1'b0}};
         count_q    <= {(NUM_KEYS*32){1'b0}};
         total_q    <= 32'd0;
      end else begin
         buf_q      <= buf_d;
         full_q     <= full_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         key_data_q <= key_data_d;
         key_len_q  <= key_len_d;
         count_q    <= count_d;
         total_q    <= total_d;
      end
   end

endmodule

// File: tb/tb_word_match_counter.sv
// Directed bench for word_match_counter: a byte-queue reference model checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_word_match_counter;

   localparam int DW  = 64;
   localparam int MWB = 16;
   localparam int NK  = 4;
   localparam int NB  = DW / 8;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_data_valid = 1'b0;
   logic              o_data_rdy;
   logic [DW-1:0]     i_data = '0;
   logic              i_flush = 1'b0;
   logic              i_clr_counts = 1'b0;
   logic              i_case_fold = 1'b0;
   logic              i_key_wr = 1'b0;
   logic [1:0]        i_key_idx = 2'd0;
   logic [8*MWB-1:0]  i_key_data = '0;
   logic [4:0]        i_key_len = 5'd0;
   logic [32*NK-1:0]  o_count;
   logic [31:0]       o_words_total;
   logic              o_busy;

   word_match_counter #(.DATA_WIDTH(DW), .MAX_WORD_BYTES(MWB), .NUM_KEYS(NK)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_data_valid(i_data_valid), .o_data_rdy(o_data_rdy),
      .i_data(i_data), .i_flush(i_flush), .i_clr_counts(i_clr_counts),
      .i_case_fold(i_case_fold), .i_key_wr(i_key_wr), .i_key_idx(i_key_idx),
      .i_key_data(i_key_data), .i_key_len(i_key_len), .o_count(o_count),
      .o_words_total(o_words_total), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int total_n = 0;
   int bad_n   = 0;

   // reference model state: pending bytes, current word, keys, counters
   logic [7:0]  m_q[$];
   logic [7:0]  m_word[$];
   bit          m_ovf = 1'b0;
   logic [31:0] m_cnt[NK];
   logic [31:0] m_total = 32'd0;
   logic [7:0]  m_key[NK][MWB];
   int          m_klen[NK];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s got=%0d want=%0d", nm, got, exp);
      end
   endtask

   function automatic bit m_matches(input int n);
      if (m_klen[n] == 0 || m_klen[n] != m_word.size() || m_ovf) return 1'b0;
      for (int j = 0; j < m_klen[n]; j++)
         if (m_key[n][j] != m_word[j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_complete();
      if (m_word.size() == 0) return;
      if (m_total != 32'hFFFF_FFFF) m_total++;
      for (int n = 0; n < NK; n++)
         if (m_matches(n) && m_cnt[n] != 32'hFFFF_FFFF) m_cnt[n]++;
      m_word.delete();
      m_ovf = 1'b0;
   endtask

   task automatic m_step();
      bit rdy_pre;
      logic [7:0] b;
      bit is_let;
      if (i_rst) begin
         m_q.delete(); m_word.delete(); m_ovf = 1'b0; m_total = 32'd0;
         for (int n = 0; n < NK; n++) begin
            m_cnt[n] = 32'd0; m_klen[n] = 0;
            for (int j = 0; j < MWB; j++) m_key[n][j] = 8'd0;
         end
         return;
      end
      rdy_pre = (m_q.size() <= 1);
      if (i_flush) m_complete();
      if (m_q.size() > 0) begin
         b = m_q.pop_front();
         is_let = 1'b0;
         if (b >= 8'h61 && b <= 8'h7A) is_let = 1'b1;
         else if (i_case_fold && b >= 8'h41 && b <= 8'h5A) begin
            is_let = 1'b1; b = b + 8'd32;
         end
         if (is_let) begin
            if (m_word.size() < MWB) m_word.push_back(b);
            else m_ovf = 1'b1;
         end else begin
            m_complete();
         end
      end
      if (i_data_valid && rdy_pre)
         for (int k = 0; k < NB; k++) m_q.push_back(i_data[k*8 +: 8]);
      if (i_clr_counts) begin
         m_total = 32'd0;
         for (int n = 0; n < NK; n++) m_cnt[n] = 32'd0;
      end
      if (i_key_wr) begin
         m_klen[i_key_idx] = int'(i_key_len);
         for (int j = 0; j < MWB; j++) m_key[i_key_idx][j] = i_key_data[j*8 +: 8];
      end
   endtask

   initial begin
      forever begin
         @(posedge i_clk or posedge i_rst);
         m_step();
      end
   end

   // every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         chk("rdy", {31'd0, o_data_rdy}, {31'd0, (m_q.size() <= 1)});
         chk("busy", {31'd0, o_busy}, {31'd0, (m_q.size() > 0 || m_word.size() > 0)});
         chk("total", o_words_total, m_total);
         for (int n = 0; n < NK; n++)
            chk($sformatf("count%0d", n), o_count[n*32 +: 32], m_cnt[n]);
      end
   end

   function automatic logic [DW-1:0] s2b(input string s, input int off);
      logic [DW-1:0] r = '0;
      for (int i = 0; i < NB; i++)
         if (off + i < s.len()) r[i*8 +: 8] = s[off+i];
      return r;
   endfunction

   function automatic logic [8*MWB-1:0] s2k(input string s);
      logic [8*MWB-1:0] r = '0;
      for (int i = 0; i < s.len() && i < MWB; i++) r[i*8 +: 8] = s[i];
      return r;
   endfunction

   time acc_t;

   task automatic send_beat(input logic [DW-1:0] d);
      bit ok = 1'b0;
      @(negedge i_clk);
      i_data_valid = 1'b1;
      i_data = d;
      for (int t = 0; t < 50; t++) begin
         if (o_data_rdy) begin
            @(posedge i_clk);
            acc_t = $time;
            ok = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_drain();
      @(negedge i_clk);
      i_data_valid = 1'b0;
      repeat (12) @(negedge i_clk);
   endtask

   task automatic send_str(input string s);
      for (int b = 0; b < (s.len() + NB - 1) / NB; b++) send_beat(s2b(s, b * NB));
      idle_drain();
   endtask

   task automatic set_key(input int idx, input string s);
      @(negedge i_clk);
      i_key_wr = 1'b1;
      i_key_idx = 2'(idx);
      i_key_data = s2k(s);
      i_key_len = 5'(s.len());
      @(negedge i_clk);
      i_key_wr = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge i_clk);
      i_clr_counts = 1'b1;
      @(negedge i_clk);
      i_clr_counts = 1'b0;
   endtask

   time t_acc[4];

   initial begin
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      chk("rst_rdy", {31'd0, o_data_rdy}, 32'd1);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_total", o_words_total, 32'd0);
      chk("rst_count", o_count[31:0] | o_count[63:32] | o_count[95:64] | o_count[127:96], 32'd0);

      // words spanning beats
      set_key(0, "hello");
      send_str("hello world hello!");
      chk("t1_cnt0", o_count[31:0], 32'd2);
      chk("t1_total", o_words_total, 32'd3);
      chk("t1_model_total", m_total, 32'd3);

      // duplicate keys
      pulse_clr();
      set_key(0, "cat"); set_key(1, "cat"); set_key(2, "dog");
      send_str("cat.dog.cat ");
      chk("t2_cnt0", o_count[31:0], 32'd2);
      chk("t2_cnt1", o_count[63:32], 32'd2);
      chk("t2_cnt2", o_count[95:64], 32'd1);
      chk("t2_cnt3", o_count[127:96], 32'd0);
      chk("t2_model_cnt2", m_cnt[2], 32'd1);

      // case folding on and off
      pulse_clr();
      set_key(0, "hello"); set_key(1, ""); set_key(2, "");
      i_case_fold = 1'b1;
      send_str("HeLLo ");
      chk("t3_fold_cnt", o_count[31:0], 32'd1);
      chk("t3_fold_total", o_words_total, 32'd1);
      pulse_clr();
      i_case_fold = 1'b0;
      send_str("HeLLo ");
      chk("t3_nofold_cnt", o_count[31:0], 32'd0);
      chk("t3_nofold_total", o_words_total, 32'd2);

      // overflow word, then exact max-length word
      pulse_clr();
      set_key(0, "abcdefghijklmnop");
      send_str("abcdefghijklmnopq ");
      chk("t4_ovf_cnt", o_count[31:0], 32'd0);
      chk("t4_ovf_total", o_words_total, 32'd1);
      send_str("abcdefghijklmnop ");
      chk("t4_max_cnt", o_count[31:0], 32'd1);
      chk("t4_max_total", o_words_total, 32'd2);

      // flush, then clear racing a completion
      pulse_clr();
      set_key(0, "hello");
      send_str("12 hello");
      chk("t5_held_busy", {31'd0, o_busy}, 32'd1);
      chk("t5_held_cnt", o_count[31:0], 32'd0);
      @(negedge i_clk); i_flush = 1'b1;
      @(negedge i_clk); i_flush = 1'b0;
      chk("t5_flush_cnt", o_count[31:0], 32'd1);
      chk("t5_flush_total", o_words_total, 32'd1);
      send_str("12 hello");
      @(negedge i_clk); i_flush = 1'b1; i_clr_counts = 1'b1;
      @(negedge i_clk); i_flush = 1'b0; i_clr_counts = 1'b0;
      chk("t5_clr_cnt", o_count[31:0], 32'd0);
      chk("t5_clr_total", o_words_total, 32'd0);

      // back-to-back beats
      for (int i = 0; i < 4; i++) begin
         send_beat(s2b("aaa bbb ", 0));
         t_acc[i] = acc_t;
      end
      idle_drain();
      for (int i = 1; i < 4; i++)
         chk($sformatf("t6_gap%0d", i), 32'((t_acc[i] - t_acc[i-1]) / 10), 32'd8);
      chk("t6_total", o_words_total, 32'd8);

      // reset in the middle of a word
      send_str("1234567h");
      chk("t7_busy_before", {31'd0, o_busy}, 32'd1);
      @(negedge i_clk); i_rst = 1'b1;
      @(negedge i_clk); i_rst = 1'b0;
      chk("t7_busy_after", {31'd0, o_busy}, 32'd0);
      set_key(0, "hello");
      send_str("ello ");
      chk("t7_cnt", o_count[31:0], 32'd0);
      chk("t7_total", o_words_total, 32'd1);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
